// File: rtl/spi_controller.sv
// spi_controller: SPI mode-0 master that sends one 16-bit frame
// {rw, addr[6:0], data[7:0]} MSB first, with programmable nCS setup,
// hold and inter-frame gap times.
// Optional feature macro: SPI_CONTROLLER_READBACK_EN adds CIPO capture of the
// data byte on read frames (rw = 0), exposed on rdata / rdata_valid.
module spi_controller #(
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [6:0] req_addr,
  input  logic [7:0] req_data,
  output logic       done,
  output logic       sCLK,
  output logic       nCS,
  output logic       COPI
`ifdef SPI_CONTROLLER_READBACK_EN
  ,
  input  logic       CIPO,
  output logic [7:0] rdata,
  output logic       rdata_valid
`endif
);

  // Terminal counts for the 8-bit phase counter (cnt_q runs 0..N-1 per phase)
  localparam logic [7:0] DIV_M1   = 8'(CLK_DIV - 1);
  localparam logic [7:0] SETUP_M1 = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_M1  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_M1   = 8'(CS_GAP - 1);
  localparam logic [7:0] GAP_M2   = 8'(CS_GAP - 2);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t      state_q;
  logic        ready_q, done_q, sclk_q, ncs_q, copi_q;
  logic [7:0]  cnt_q;
  logic [4:0]  bit_q;
  logic [15:0] sh_q;
`ifdef SPI_CONTROLLER_READBACK_EN
  logic        rw_q;
  logic [7:0]  rsh_q, rdata_q;
  logic        rvld_q;
`endif

  // Frame sequencer: every output is a register updated here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
`ifdef SPI_CONTROLLER_READBACK_EN
      rw_q    <= 1'b0;
      rsh_q   <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef SPI_CONTROLLER_READBACK_EN
      rvld_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req_valid && ready_q) begin
            // Bit 15 is presented immediately so it is settled long before
            // the first rising edge.
            sh_q    <= {req_rw, req_addr, req_data};
            copi_q  <= req_rw;
            ncs_q   <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
            state_q <= SETUP;
`ifdef SPI_CONTROLLER_READBACK_EN
            rw_q    <= req_rw;
            rsh_q   <= '0;
`endif
          end else begin
            // Also raises ready on the first cycle after reset release
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_q == SETUP_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SHIFT: begin
          if (cnt_q == DIV_M1) begin
            cnt_q <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
`ifdef SPI_CONTROLLER_READBACK_EN
              // Data byte occupies bits 8..15 of a read frame
              if (!rw_q && bit_q[3]) rsh_q <= {rsh_q[6:0], CIPO};
`endif
            end else begin
              // Falling edge: the only point where COPI may change
              sclk_q <= 1'b0;
              if (bit_q == 5'd15) begin
                state_q <= HOLD;
              end else begin
                bit_q  <= bit_q + 5'd1;
                sh_q   <= {sh_q[14:0], 1'b0};
                copi_q <= sh_q[14];
              end
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_M1) begin
            cnt_q   <= '0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_M1) begin
            cnt_q   <= '0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
            // Registered, so it lands on the final GAP cycle
            if (cnt_q == GAP_M2) begin
              done_q <= 1'b1;
`ifdef SPI_CONTROLLER_READBACK_EN
              if (!rw_q) begin
                rdata_q <= rsh_q;
                rvld_q  <= 1'b1;
              end
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign done      = done_q;
  assign sCLK      = sclk_q;
  assign nCS       = ncs_q;
  assign COPI      = copi_q;
`ifdef SPI_CONTROLLER_READBACK_EN
  assign rdata       = rdata_q;
  assign rdata_valid = rvld_q;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: directed bench for spi_controller. A default-parameter
// instance is checked bit-by-bit against a queue of expected COPI bits; a
// CLK_DIV = 4 instance checks sCLK period and COPI stability.
module tb_spi_controller;
  localparam int CLK_DIV = 8, CS_SETUP = 4, CS_HOLD = 4, CS_GAP = 8;
  // Cycles from the accept cycle to the done cycle, both inclusive
  localparam int FRAME_CYC  = 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD + CS_GAP;
  localparam int FRAME_CYC4 = 1 + CS_SETUP + 32*4 + CS_HOLD + CS_GAP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance
  logic       req_valid = 1'b0, req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       req_ready, done, sclk, ncs, copi;
  // CLK_DIV = 4 instance
  logic       b_valid = 1'b0, b_rw = 1'b0;
  logic [6:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_done, b_sclk, b_ncs, b_copi;

`ifdef SPI_CONTROLLER_READBACK_EN
  logic       cipo;
  logic [7:0] rdata, b_rdata;
  logic       rdata_valid, b_rdata_valid;
  logic [15:0] rb_pat = 16'h0000;
  int          rb_base = 0;
  logic        done_rv = 1'b0;
`endif

  spi_controller #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data), .done(done),
    .sCLK(sclk), .nCS(ncs), .COPI(copi)
`ifdef SPI_CONTROLLER_READBACK_EN
    , .CIPO(cipo), .rdata(rdata), .rdata_valid(rdata_valid)
`endif
  );

  spi_controller #(.CLK_DIV(4), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready),
    .req_rw(b_rw), .req_addr(b_addr), .req_data(b_data), .done(b_done),
    .sCLK(b_sclk), .nCS(b_ncs), .COPI(b_copi)
`ifdef SPI_CONTROLLER_READBACK_EN
    , .CIPO(1'b0), .rdata(b_rdata), .rdata_valid(b_rdata_valid)
`endif
  );

  int checks = 0, errors = 0;
  bit exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor for the default instance: scoreboard pop on every sCLK rise,
  // nCS-high run length, COPI idle level, done count.
  int   rises = 0, ncs_run = 0, gap_run = 0, idle_bad = 0, done_cnt = 0;
  logic sclk_p = 1'b0, ncs_p = 1'b1;
  always @(negedge clk) begin
    if (rst) begin
      sclk_p <= 1'b0;
      ncs_p  <= 1'b1;
    end else begin
      if (sclk && !sclk_p) begin
        rises <= rises + 1;
        if (exp_q.size() == 0) check("copi_extra_edge", 32'd1, 32'd0);
        else check("copi_bit", {31'd0, copi}, {31'd0, exp_q.pop_front()});
      end
      if (ncs) begin
        ncs_run <= ncs_run + 1;
        if (copi !== 1'b0) idle_bad <= idle_bad + 1;
      end else begin
        if (ncs_p) gap_run <= ncs_run;
        ncs_run <= 0;
      end
      if (done) done_cnt <= done_cnt + 1;
      sclk_p <= sclk;
      ncs_p  <= ncs;
    end
  end

`ifdef SPI_CONTROLLER_READBACK_EN
  // Peripheral model: presents bit i of rb_pat during the low phase of bit i
  always_comb begin
    int idx;
    idx  = rises - rb_base;
    cipo = 1'b0;
    if (idx >= 0 && idx < 16) cipo = rb_pat[4'(15 - idx)];
  end
`endif

  task automatic present_a(input logic rw, input logic [6:0] addr, input logic [7:0] data);
    logic [15:0] f;
    f = {rw, addr, data};
    req_rw = rw; req_addr = addr; req_data = data;
    for (int i = 15; i >= 0; i--) exp_q.push_back(f[i]);
  endtask

  task automatic wait_ready_a(input string tag);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 2000);
    if (!req_ready) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  // Called just after the accept edge; returns accept-to-done cycle count
  task automatic wait_done(input bit scramble, output int cyc, output bit ready_seen);
    int k;
    k = 0; cyc = -1; ready_seen = 1'b0;
    while (k < 2000) begin
      @(negedge clk); k++;
      if (req_ready) ready_seen = 1'b1;
      if (done) begin
        cyc = k + 1;
`ifdef SPI_CONTROLLER_READBACK_EN
        done_rv = rdata_valid;
`endif
        break;
      end
      if (scramble) begin
        req_rw = 1'($urandom); req_addr = 7'($urandom); req_data = 8'($urandom);
      end
    end
  endtask

  task automatic single_a(input string tag, input logic rw, input logic [6:0] addr, input logic [7:0] data);
    int cyc, r0; bit rs;
    wait_ready_a(tag);
    r0 = rises;
    present_a(rw, addr, data);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(1'b1, cyc, rs);
    check({tag, "_frame_cycles"}, cyc, FRAME_CYC);
    check({tag, "_ready_busy"}, {31'd0, rs}, 32'd0);
    @(negedge clk);
    check({tag, "_rises"}, rises - r0, 32'd16);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  // CLK_DIV = 4 frame with inputs toggling throughout
  task automatic run4;
    logic [15:0] f;
    logic s_p, c_p;
    int k, r, last_rise, last_chg, per_bad, stab_bad, cyc;
    f = {1'b0, 7'h7F, 8'h5A};
    k = 0;
    do begin @(negedge clk); k++; end while (!b_ready && k < 2000);
    if (!b_ready) check("t4_ready_timeout", 32'd0, 32'd1);
    b_rw = f[15]; b_addr = f[14:8]; b_data = f[7:0]; b_valid = 1'b1;
    @(posedge clk); #1;
    s_p = 1'b0; c_p = b_copi; k = 0; r = 0; cyc = -1;
    last_rise = -100; last_chg = 0; per_bad = 0; stab_bad = 0;
    while (k < 1000) begin
      @(negedge clk); k++;
      if (b_copi !== c_p) begin
        if (k - last_rise < 4) stab_bad++;
        last_chg = k;
      end
      if (b_sclk && !s_p) begin
        if (r < 16) check("t4_copi_bit", {31'd0, b_copi}, {31'd0, f[4'(15 - r)]});
        else check("t4_extra_edge", 32'd1, 32'd0);
        if (r > 0 && k - last_rise != 8) per_bad++;
        if (k - last_chg < 4) stab_bad++;
        last_rise = k;
        r++;
      end
      s_p = b_sclk; c_p = b_copi;
      if (b_done) begin cyc = k + 1; break; end
      b_valid = 1'($urandom); b_rw = 1'($urandom);
      b_addr = 7'($urandom); b_data = 8'($urandom);
    end
    b_valid = 1'b0;
    check("t4_frame_cycles", cyc, FRAME_CYC4);
    check("t4_rises", r, 32'd16);
    check("t4_period_bad", per_bad, 32'd0);
    check("t4_stable_bad", stab_bad, 32'd0);
  endtask

  initial begin
    int c1, c2, r0, d0, k;
    bit rs1, rs2;
    // Reset
    repeat (3) @(negedge clk);
    check("rst_ncs", {31'd0, ncs}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_copi", {31'd0, copi}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ready_low", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rst_ready_after", {31'd0, req_ready}, 32'd1);
    check("rst_ncs_after", {31'd0, ncs}, 32'd1);

    // Write frame
    single_a("wr", 1'b1, 7'h00, 8'hA5);

    // Back-to-back with req_valid held high
    wait_ready_a("b2b");
    r0 = rises;
    present_a(1'b1, 7'h04, 8'h80);
    req_valid = 1'b1;
    @(posedge clk); #1;
    present_a(1'b1, 7'h02, 8'hFF);
    wait_done(1'b0, c1, rs1);
    @(posedge clk); @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(1'b0, c2, rs2);
    check("b2b_f1_cycles", c1, FRAME_CYC);
    check("b2b_f1_ready_busy", {31'd0, rs1}, 32'd0);
    check("b2b_f2_cycles", c2, FRAME_CYC);
    check("b2b_ncs_gap", gap_run, CS_GAP + 1);
    @(negedge clk);
    check("b2b_rises", rises - r0, 32'd32);
    check("b2b_queue_empty", exp_q.size(), 32'd0);

    // Abort after the 5th rising edge
    wait_ready_a("abort");
    r0 = rises; d0 = done_cnt;
    present_a(1'b1, 7'h55, 8'h33);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (rises - r0 < 5 && k < 2000) begin @(negedge clk); k++; end
    check("abort_reached_5", rises - r0, 32'd5);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ncs", {31'd0, ncs}, 32'd1);
    check("abort_sclk", {31'd0, sclk}, 32'd0);
    check("abort_copi", {31'd0, copi}, 32'd0);
    check("abort_bits_left", exp_q.size(), 32'd11);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (400) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 32'd0);
    check("abort_ready", {31'd0, req_ready}, 32'd1);

    // Timing with CLK_DIV = 4
    run4();

`ifdef SPI_CONTROLLER_READBACK_EN
    // Read frame: peripheral returns 0x3C in the data bits
    rb_base = rises;
    rb_pat  = 16'h003C;
    single_a("rd", 1'b0, 7'h11, 8'h00);
    check("rd_rdata", {24'd0, rdata}, 32'h3C);
    check("rd_valid_with_done", {31'd0, done_rv}, 32'd1);
    single_a("rd_wr", 1'b1, 7'h12, 8'hC3);
    check("rd_wr_rdata_hold", {24'd0, rdata}, 32'h3C);
    check("rd_wr_no_valid", {31'd0, done_rv}, 32'd0);
`endif

    check("copi_idle_zero", idle_bad, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/spi_controller.md
SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001 Parameter CLK_DIV, default 8, sets sCLK half-period in clk cycles; legal range 4..255.
REQ-002 Parameter CS_SETUP, default 4, sets clk cycles from nCS falling to first sCLK rising; legal range 1..255.
REQ-003 Parameter CS_HOLD, default 4, sets clk cycles from last sCLK falling to nCS rising; legal range 1..255.
REQ-004 Parameter CS_GAP, default 8, sets minimum clk cycles nCS stays high between frames; legal range 4..255.
REQ-005 Port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1, synchronous, active-high reset.
REQ-007 Port req_valid, input, 1, the requester has a frame to send.
REQ-008 Port req_ready, output, 1, the controller can accept a frame.
REQ-009 Port req_rw, input, 1, frame R/W bit (1 = write).
REQ-010 Port req_addr, input, 7, register address.
REQ-011 Port req_data, input, 8, write data.
REQ-012 Port done, output, 1, one-cycle pulse when a frame completes.
REQ-013 Port sCLK, output, 1, SPI serial clock, mode 0 (idle low).
REQ-014 Port nCS, output, 1, active-low chip select.
REQ-015 Port COPI, output, 1, serial data to the peripheral.

Function
REQ-016 State machine with states IDLE, SETUP, SHIFT, HOLD, GAP; all outputs registered.
REQ-017 req_ready is high only in IDLE; a frame is accepted on a clk edge where req_valid and req_ready are both high.
REQ-018 On accept, {req_rw, req_addr, req_data} is latched into a 16-bit shift register; inputs are ignored until the next accept.
REQ-019 On the cycle after accept, nCS = 0, sCLK = 0, COPI = frame bit 15 (rw), and the state is SETUP.
REQ-020 SETUP lasts CS_SETUP cycles, then enters SHIFT.
REQ-021 SHIFT sends 16 bits MSB first: rw, addr[6:0], data[7:0].
REQ-022 Each bit has a low phase of CLK_DIV cycles followed by a high phase of CLK_DIV cycles.
REQ-023 COPI changes only while sCLK is low (at the falling edge); it is stable for at least CLK_DIV cycles before and after each rising edge.
REQ-024 A 5-bit bit counter counts 0..15; after the 16th high phase sCLK returns low and the state becomes HOLD.
REQ-025 Exactly 16 sCLK rising edges occur per frame.
REQ-026 HOLD keeps nCS low for CS_HOLD cycles; nCS then goes high and the state becomes GAP.
REQ-027 GAP lasts CS_GAP cycles; done pulses high for one cycle on the final GAP cycle; the next state is IDLE.
REQ-028 Frame length from accept to done is 1 + CS_SETUP + 32*CLK_DIV + CS_HOLD + CS_GAP cycles.
REQ-029 The earliest next accept is the cycle after done; nCS rising-to-falling spacing is therefore at least CS_GAP + 1 cycles.
REQ-030 COPI = 0 while nCS is high.
REQ-031 Phase counters are 8 bits wide and never wrap mid-phase; out-of-range parameters are unsupported.

Reset
REQ-032 rst, sampled on clk, forces the following on the next edge: state IDLE, nCS = 1, sCLK = 0, COPI = 0, done = 0, and counters and shift register cleared.
REQ-033 rst mid-frame aborts without a done pulse; the peripheral sees a short frame and discards it.
REQ-034 req_ready is low while rst is high, and high from the first cycle after rst deasserts.

Configuration
REQ-035 With SPI_CONTROLLER_READBACK_EN defined, input CIPO (1 bit) and outputs rdata (8 bits, reset 0x00) and rdata_valid (1 bit) are added.
REQ-036 With the macro defined, for frames with rw = 0, CIPO is sampled at each sCLK rising edge of bits 8..15 into rdata, MSB first; rdata_valid pulses with done.
REQ-037 With the macro defined, rdata holds its value after a write frame.
REQ-038 Without the macro, CIPO, rdata and rdata_valid do not exist and read frames are shifted out identically to writes.

Verification
REQ-039 Reset scenario: apply rst -> nCS = 1, sCLK = 0, COPI = 0, done = 0, and req_ready = 1 one cycle after release.
REQ-040 Write scenario: rw = 1, addr = 0x00, data = 0xA5 with defaults -> COPI at the rising edges reads 1,0000000,10100101; 16 rising edges; done exactly 1 + 4 + 256 + 4 + 8 = 273 cycles after accept.
REQ-041 Back-to-back scenario: req_valid held high with two frames (addr 0x04 / 0x80, addr 0x02 / 0xFF) -> req_ready low throughout frame 1; nCS high for at least 9 cycles between frames; both frames are bit-exact.
REQ-042 Abort scenario: assert rst after the 5th rising edge -> nCS = 1 and sCLK = 0 on the next edge; no done pulse.
REQ-043 Timing scenario: CLK_DIV = 4 -> sCLK period is 8 clk cycles, COPI is stable for 4 cycles either side of each rising edge, and input changes during a frame have no effect.
REQ-044 Readback scenario: with SPI_CONTROLLER_READBACK_EN defined, an rw = 0 frame with CIPO driving 0x3C during the data bits -> rdata = 0x3C and rdata_valid coincides with done.
